if_id_skid: RTL and testbench

Parametrised instruction-fetch-to-decode pipeline stage with valid/ready handshake and a one-entry skid buffer. It sits between the fetch unit and decode. Fetch can stream at full rate while decode back-pressure is absorbed without a combinational ready path. A flush from ctrl squashes everything held and drives a NOP downstream.

---
 rtl/if_id_skid_if.sv | 30 +++
 rtl/if_id_skid.sv | 100 ++++++++++
 tb/tb_if_id_skid.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/if_id_skid_if.sv
// Handshake bundle between fetch, the IF/ID stage and decode.
// The stage sits on the slave side; fetch and decode sit on the master side.
interface if_id_skid_if #(
    parameter int IW = 32,
    parameter int AW = 32
);
    // Fetch -> stage
    logic [IW-1:0] inst_i;
    logic [AW-1:0] inst_addr_i;
    logic          valid_i;
    logic          ready_o;

    // Stage -> decode
    logic [IW-1:0] inst_o;
    logic [AW-1:0] inst_addr_o;
    logic          valid_o;
    logic          ready_i;

    // Environment side: fetch drives the input, decode drives ready.
    modport master (
        output inst_i, inst_addr_i, valid_i, ready_i,
        input  ready_o, inst_o, inst_addr_o, valid_o
    );

    // Pipeline stage side.
    modport slave (
        input  inst_i, inst_addr_i, valid_i, ready_i,
        output ready_o, inst_o, inst_addr_o, valid_o
    );
endinterface

// File: rtl/if_id_skid.sv
// IF/ID pipeline stage with a one-entry skid buffer.
// Main entry M drives decode; skid entry S catches the one extra instruction
// fetch can push during the first stalled cycle, so ready_o comes straight
// from a flop and never depends combinationally on ready_i.
module if_id_skid #(
    parameter int            IW       = 32,
    parameter int            AW       = 32,
    parameter logic [IW-1:0] NOP_VAL  = 32'h0000_0013,
    parameter logic [AW-1:0] ADDR_RST = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    if_id_skid_if.slave  bus
);

    logic          m_valid_q, m_valid_d;
    logic [IW-1:0] m_inst_q,  m_inst_d;
    logic [AW-1:0] m_addr_q,  m_addr_d;

    logic          s_valid_q, s_valid_d;
    logic [IW-1:0] s_inst_q,  s_inst_d;
    logic [AW-1:0] s_addr_q,  s_addr_d;

    logic          ready;
    logic          acc;
    logic          drn;

    assign ready = ~s_valid_q;
    assign acc   = bus.valid_i & ready;
    assign drn   = m_valid_q & bus.ready_i;

    // Next-state for both entries; flush overrides every other event.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        m_valid_d = m_valid_q;
        m_inst_d  = m_inst_q;
        m_addr_d  = m_addr_q;
        s_valid_d = s_valid_q;
        s_inst_d  = s_inst_q;
        s_addr_d  = s_addr_q;

        if (flush_i) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (!s_valid_q) begin
            if (acc) begin
                if (!m_valid_q || drn) begin
                    // M is free or emptying this cycle: input goes straight to M.
                    m_valid_d = 1'b1;
                    m_inst_d  = bus.inst_i;
                    m_addr_d  = bus.inst_addr_i;
                end else begin
                    // M is stalled: park the input in S, ready_o drops next cycle.
                    s_valid_d = 1'b1;
                    s_inst_d  = bus.inst_i;
                    s_addr_d  = bus.inst_addr_i;
                end
            end else if (drn) begin
                m_valid_d = 1'b0;
            end
        end else if (drn) begin
            // S refills M in order; ready_o is held low so nothing new arrives.
            m_valid_d = 1'b1;
            m_inst_d  = s_inst_q;
            m_addr_d  = s_addr_q;
            s_valid_d = 1'b0;
        end
    end

    // Valid flags: the only state that must be cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
        end
    end

    // Payload registers; contents of an invalid entry are never observed.
    always_ff @(posedge clk) begin
        // NOTE: data is deliberately not reset; outputs are masked by the valid flags.
        m_inst_q <= m_inst_d;
        m_addr_q <= m_addr_d;
        s_inst_q <= s_inst_d;
        s_addr_q <= s_addr_d;
    end

    // Outputs: M when live, otherwise the NOP/reset-address pair.
    always_comb begin
        bus.ready_o     = ready;
        bus.valid_o     = m_valid_q;
        bus.inst_o      = m_valid_q ? m_inst_q : NOP_VAL;
        bus.inst_addr_o = m_valid_q ? m_addr_q : ADDR_RST;
    end

endmodule

// File: tb/tb_if_id_skid.sv
// Bench for if_id_skid: queue-based reference model checked every cycle,
// directed sequences with literal expectations, and a narrow-width instance.
module tb_if_id_skid;

    logic clk;
    logic rst_n;
    logic flush_i;
    logic flush2_i;

    int total = 0;
    int bad   = 0;

    if_id_skid_if #(.IW(32), .AW(32)) u_if ();
    if_id_skid_if #(.IW(16), .AW(12)) u_if2 ();

    if_id_skid #(
        .IW(32), .AW(32), .NOP_VAL(32'h0000_0013), .ADDR_RST(32'h0)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .bus(u_if)
    );

    if_id_skid #(
        .IW(16), .AW(12), .NOP_VAL(16'h0001), .ADDR_RST(12'h000)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush2_i), .bus(u_if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: an ordered FIFO of at most two entries
    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
    } ent_t;

    ent_t mq[$];
    bit   m_acc;
    bit   m_drn;
    ent_t m_new;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
        end else begin
            m_acc = u_if.valid_i && (mq.size() < 2);
            m_drn = (mq.size() > 0) && u_if.ready_i;
            if (flush_i) begin
                mq.delete();
            end else begin
                if (m_drn) void'(mq.pop_front());
                if (m_acc) begin
                    m_new.inst = u_if.inst_i;
                    m_new.addr = u_if.inst_addr_i;
                    mq.push_back(m_new);
                end
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("mdl_valid", 64'(u_if.valid_o), 64'(mq.size() > 0));
            check("mdl_ready", 64'(u_if.ready_o), 64'(mq.size() < 2));
            check("mdl_inst",  64'(u_if.inst_o),  (mq.size() > 0) ? 64'(mq[0].inst) : 64'h13);
            check("mdl_addr",  64'(u_if.inst_addr_o), (mq.size() > 0) ? 64'(mq[0].addr) : 64'h0);
        end
    end

    // ---------------- stimulus helpers
    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Drive one cycle of inputs (called at a negedge), return at the next negedge.
    task automatic step(input logic v, input logic [31:0] a, input logic r, input logic f);
        u_if.valid_i     = v;
        u_if.inst_addr_i = a;
        u_if.inst_i      = inst_of(a);
        u_if.ready_i     = r;
        flush_i          = f;
        @(negedge clk);
    endtask

    // Literal expectation for the 32-bit instance.
    task automatic expect_out(input string tag, input logic v, input logic [31:0] a, input logic rdy);
        check({tag, "_valid"}, 64'(u_if.valid_o), 64'(v));
        check({tag, "_addr"},  64'(u_if.inst_addr_o), v ? 64'(a) : 64'h0);
        check({tag, "_inst"},  64'(u_if.inst_o), v ? 64'(inst_of(a)) : 64'h13);
        check({tag, "_ready"}, 64'(u_if.ready_o), 64'(rdy));
    endtask

    task automatic step2(input logic v, input logic [15:0] i, input logic [11:0] a, input logic r);
        u_if2.valid_i     = v;
        u_if2.inst_i      = i;
        u_if2.inst_addr_i = a;
        u_if2.ready_i     = r;
        @(negedge clk);
    endtask

    task automatic expect2(input string tag, input logic v, input logic [15:0] i,
                           input logic [11:0] a, input logic rdy);
        check({tag, "_valid"}, 64'(u_if2.valid_o), 64'(v));
        check({tag, "_inst"},  64'(u_if2.inst_o), 64'(i));
        check({tag, "_addr"},  64'(u_if2.inst_addr_o), 64'(a));
        check({tag, "_ready"}, 64'(u_if2.ready_o), 64'(rdy));
    endtask

    // ---------------- main sequence
    initial begin
        rst_n             = 1'b0;
        flush_i           = 1'b0;
        flush2_i          = 1'b0;
        u_if.valid_i      = 1'b0;
        u_if.inst_i       = '0;
        u_if.inst_addr_i  = '0;
        u_if.ready_i      = 1'b0;
        u_if2.valid_i     = 1'b0;
        u_if2.inst_i      = '0;
        u_if2.inst_addr_i = '0;
        u_if2.ready_i     = 1'b1;

        // Reset state, before and across a clock edge.
        #3;
        expect_out("rst0", 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        expect_out("rst1", 1'b0, 32'h0, 1'b1);
        rst_n = 1'b1;

        // Streaming: one-cycle latency, no bubbles, ready stays high.
        step(1'b1, 32'h0, 1'b1, 1'b0); expect_out("str0", 1'b1, 32'h0, 1'b1);
        step(1'b1, 32'h4, 1'b1, 1'b0); expect_out("str1", 1'b1, 32'h4, 1'b1);
        step(1'b1, 32'h8, 1'b1, 1'b0); expect_out("str2", 1'b1, 32'h8, 1'b1);
        step(1'b1, 32'hC, 1'b1, 1'b0); expect_out("str3", 1'b1, 32'hC, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0); expect_out("str_end", 1'b0, 32'h0, 1'b1);

        // Skid: decode stalls while 0x14 is on the outputs, 0x18 lands in S.
        step(1'b1, 32'h10, 1'b1, 1'b0); expect_out("skd0", 1'b1, 32'h10, 1'b1);
        step(1'b1, 32'h14, 1'b1, 1'b0); expect_out("skd1", 1'b1, 32'h14, 1'b1);
        step(1'b1, 32'h18, 1'b0, 1'b0); expect_out("skd2", 1'b1, 32'h14, 1'b0);
        step(1'b0, 32'h0,  1'b0, 1'b0); expect_out("skd3", 1'b1, 32'h14, 1'b0);
        step(1'b0, 32'h0,  1'b0, 1'b0); expect_out("skd4", 1'b1, 32'h14, 1'b0);
        step(1'b0, 32'h0,  1'b1, 1'b0); expect_out("skd5", 1'b1, 32'h18, 1'b1);
        step(1'b0, 32'h0,  1'b1, 1'b0); expect_out("skd6", 1'b0, 32'h0,  1'b1);

        // Flush with both entries full; 0x28 is offered and must vanish.
        step(1'b1, 32'h20, 1'b1, 1'b0); expect_out("fl0", 1'b1, 32'h20, 1'b1);
        step(1'b1, 32'h24, 1'b0, 1'b0); expect_out("fl1", 1'b1, 32'h20, 1'b0);
        step(1'b1, 32'h28, 1'b0, 1'b1); expect_out("fl2", 1'b0, 32'h0,  1'b1);
        step(1'b1, 32'h40, 1'b1, 1'b0); expect_out("fl3", 1'b1, 32'h40, 1'b1);
        step(1'b0, 32'h0,  1'b1, 1'b0); expect_out("fl4", 1'b0, 32'h0,  1'b1);

        // Flush collision: drain, accept and flush in one cycle.
        step(1'b1, 32'h50, 1'b1, 1'b0); expect_out("col0", 1'b1, 32'h50, 1'b1);
        step(1'b1, 32'h54, 1'b1, 1'b1); expect_out("col1", 1'b0, 32'h0,  1'b1);
        step(1'b0, 32'h0,  1'b1, 1'b0); expect_out("col2", 1'b0, 32'h0,  1'b1);

        // Asynchronous reset mid-stream clears outputs without a clock edge.
        step(1'b1, 32'h60, 1'b0, 1'b0); expect_out("ar0", 1'b1, 32'h60, 1'b1);
        step(1'b1, 32'h64, 1'b0, 1'b0); expect_out("ar1", 1'b1, 32'h60, 1'b0);
        #2 rst_n = 1'b0;
        #1 expect_out("ar2", 1'b0, 32'h0, 1'b1);
        u_if.valid_i = 1'b0;
        @(negedge clk);
        expect_out("ar3", 1'b0, 32'h0, 1'b1);
        rst_n = 1'b1;

        // Random traffic, checked cycle by cycle against the model.
        for (int n = 0; n < 10000; n++) begin
            step(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0, ($urandom % 16) == 0);
        end
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        expect_out("rnd_end", 1'b0, 32'h0, 1'b1);

        // Narrow instance: masking value and widths follow the parameters.
        expect2("p0", 1'b0, 16'h0001, 12'h000, 1'b1);
        step2(1'b1, 16'hBEEF, 12'hABC, 1'b1); expect2("p1", 1'b1, 16'hBEEF, 12'hABC, 1'b1);
        step2(1'b1, 16'h1234, 12'h004, 1'b0); expect2("p2", 1'b1, 16'hBEEF, 12'hABC, 1'b0);
        step2(1'b0, 16'h0000, 12'h000, 1'b0); expect2("p3", 1'b1, 16'hBEEF, 12'hABC, 1'b0);
        step2(1'b0, 16'h0000, 12'h000, 1'b1); expect2("p4", 1'b1, 16'h1234, 12'h004, 1'b1);
        step2(1'b0, 16'h0000, 12'h000, 1'b1); expect2("p5", 1'b0, 16'h0001, 12'h000, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
